mem_stage_ctrl: RTL
===================

# mem_stage_ctrl

Memory-stage controller for the pipelined MIPS core. It consumes the EX/MEM pipeline register outputs and drives a request/acknowledge data-memory port. It stalls the upstream pipeline while an access is outstanding, then loads its internal MEM/WB pipeline register with the write-back bundle. It is the read side of the EX/MEM interface: whatever EX/MEM holds is executed here and retired toward write-back.

## Interface

Parameters:
- TIMEOUT, 15: maximum WAIT cycles before an access is abandoned (only with MEM_TIMEOUT_EN); legal range 1–255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- wbIn  input  2  from EX/MEM; [1] regWrite, [0] memToReg.
- mIn  input  2  from EX/MEM; [1] memRead, [0] memWrite.
- resultIn  input  32  ALU result; memory byte address for loads/stores.
- writeDataIn  input  32  store data.
- registerRdIn  input  5  destination register.
- memStall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
- memReq  output  1  memory request, registered.
- memWe  output  1  1 = write, 0 = read; valid while memReq.
- memAddr  output  32  registered address.
- memWData  output  32  registered store data.
- memAck  input  1  one-cycle completion pulse from memory.
- memRData  input  32  load data, valid when memAck.
- wbOut  output  2  MEM/WB regWrite/memToReg.
- readDataOut  output  32  MEM/WB load data.
- resultOut  output  32  MEM/WB ALU result.
- registerRdOut  output  5  MEM/WB destination.
- memErr  output  1  sticky timeout flag (0 when MEM_TIMEOUT_EN is undefined).

## Operation

- memOp = mIn[1] | mIn[0]. If both bits are set, the access is a read; the write is suppressed.
- FSM states: IDLE, WAIT.
- IDLE, memOp = 0:
  - memStall = 0.
  - MEM/WB loads wbIn, resultIn, and registerRdIn; readDataOut loads 0.
- IDLE, memOp = 1:
  - memStall = 1.
  - Next edge: go to WAIT; memReq←1; memWe←(mIn==2'b01); memAddr←resultIn; memWData←writeDataIn.
  - Capture wbIn and registerRdIn into holding registers.
  - MEM/WB loads a bubble: wbOut←0, other fields hold.
- WAIT, memAck = 0:
  - memStall = 1; MEM/WB loads a bubble.
- WAIT, memAck = 1:
  - memStall = 0; upstream advances on the same edge.
  - Next edge: go to IDLE; memReq←0.
  - MEM/WB loads the held wb and rd, resultOut←memAddr, readDataOut←(read ? memRData : 0).
- memAck in IDLE is ignored.
- memAddr, memWData, and memWe are stable for the whole request; EX/MEM inputs are don't-care in WAIT.
- The bubble (wbOut=0) prevents duplicate register-file writes while stalled.

## Timing

- Reset (asynchronous): state IDLE; memReq, memWe, memAddr, memWData, wbOut, readDataOut, resultOut, registerRdOut, memErr, and the timeout counter all go to 0. memStall is combinational and follows the FSM.
- Reset mid-access drops memReq immediately; any late memAck after reset is ignored.
- Non-memory op: 1-cycle latency through MEM/WB, no stall.
- Memory op with ack in the n-th WAIT cycle (n≥1): memStall is high for n cycles (the IDLE issue cycle plus n−1 WAIT cycles), and MEM/WB is valid n+1 cycles after presentation.
- Back-to-back memory ops: the next op is presented the cycle after ack and reissues from IDLE, so there is no request overlap and memReq drops for at least one cycle.

## Configuration

- MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and increments on each WAIT cycle without memAck.
  - When the count equals TIMEOUT without ack: go to IDLE, memReq←0, MEM/WB takes a bubble, and memErr←1 (sticky until rst).
  - memStall is 0 in that cycle and the instruction is dropped.
  - If ack and timeout coincide, ack wins.
- MEM_TIMEOUT_EN undefined: no counter; WAIT persists until memAck; memErr is tied to 0.

## Test plan

- Reset mid-WAIT: rst at cycle 3 -> memReq=0 and all outputs 0 asynchronously; memAck at cycle 4 causes no MEM/WB load.
- ALU op: wbIn=2'b10, mIn=0, resultIn=0x1234, registerRdIn=7 -> next cycle wbOut=2'b10, resultOut=0x1234, registerRdOut=7, readDataOut=0, memStall never high.
- Load, ack in 3rd WAIT cycle: mIn=2'b10, resultIn=0x100, memRData=0xDEADBEEF -> memReq high 3 cycles with memAddr=0x100 and memWe=0; memStall high 3 cycles; then wbOut=2'b11, readDataOut=0xDEADBEEF; wbOut=0 during the stall.
- Store, immediate ack: mIn=2'b01, writeDataIn=0xA5A5A5A5 -> memWe=1, memWData=0xA5A5A5A5, one stall cycle, readDataOut=0.
- mIn=2'b11 -> memWe=0 (read).
- With MEM_TIMEOUT_EN and TIMEOUT=4, no ack -> memReq drops after 4 WAIT cycles, memErr=1 and stays 1, next ALU op proceeds normally. Ack on cycle 4 instead -> normal completion, memErr=0.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage req/ack data-memory controller feeding MEM/WB; define MEM_TIMEOUT_EN to abandon accesses after TIMEOUT WAIT cycles
module mem_stage_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wbIn,
  input  logic [1:0]  mIn,
  input  logic [31:0] resultIn,
  input  logic [31:0] writeDataIn,
  input  logic [4:0]  registerRdIn,
  output logic        memStall,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic        memAck,
  input  logic [31:0] memRData,
  output logic [1:0]  wbOut,
  output logic [31:0] readDataOut,
  output logic [31:0] resultOut,
  output logic [4:0]  registerRdOut,
  output logic        memErr
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      r_state;
  logic [1:0]  r_wb;
  logic [4:0]  r_rd;
  logic        w_op;
  logic        w_to;
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end
  assign w_op = |mIn;
`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_cnt;
  // the TIMEOUT-th ackless WAIT cycle is the last one; an ack in that cycle still completes
  assign w_to = r_state == WAIT && !memAck && r_cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      memErr <= 1'b0;
    end else begin
      r_cnt  <= r_state == IDLE ? '0 : memAck ? r_cnt : r_cnt + 8'd1;
      memErr <= memErr | w_to;
    end
  end
`else
  assign w_to   = 1'b0;
  assign memErr = 1'b0;
`endif
  assign memStall = r_state == IDLE ? w_op : !(memAck || w_to);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_wb          <= '0;
      r_rd          <= '0;
      memReq        <= 1'b0;
      memWe         <= 1'b0;
      memAddr       <= '0;
      memWData      <= '0;
      wbOut         <= '0;
      readDataOut   <= '0;
      resultOut     <= '0;
      registerRdOut <= '0;
    end else if (r_state == IDLE) begin
      if (w_op) begin
        r_state  <= WAIT;
        memReq   <= 1'b1;
        memWe    <= mIn == 2'b01;
        memAddr  <= resultIn;
        memWData <= writeDataIn;
        r_wb     <= wbIn;
        r_rd     <= registerRdIn;
        wbOut    <= '0;
      end else begin
        wbOut         <= wbIn;
        resultOut     <= resultIn;
        registerRdOut <= registerRdIn;
        readDataOut   <= '0;
      end
    end else if (memAck) begin
      r_state       <= IDLE;
      memReq        <= 1'b0;
      wbOut         <= r_wb;
      registerRdOut <= r_rd;
      resultOut     <= memAddr;
      readDataOut   <= memWe ? '0 : memRData;
    end else begin
      wbOut <= '0;
      if (w_to) begin
        r_state <= IDLE;
        memReq  <= 1'b0;
      end
    end
  end
endmodule
